sound_sequencer: RTL and testbench
==================================

Name: sound_sequencer

Overview:
Timed command player that drives the 4-channel square-wave sound block's write port. The CPU pushes note words and wait words into a FIFO. The sequencer pops them and emits one-cycle sound-register writes, paced by a tick prescaler, so melodies play without CPU timing. A flush aborts playback and silences all four channels.

Parameters:
DEPTH, 16, FIFO entries; power of 2, ≥2
TICK_DIV, 1000, clocks per wait tick; ≥1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  peripheral select
wr_en  in  1  CPU write strobe; a push happens when en && wr_en
addr  in  1  0 = note word, 1 = wait word
data_in  in  16  note: [15:14] channel, [13:0] divider (0 = channel off); wait: tick count W
flush  in  1  one-cycle abort/silence request
snd_wr_en  out  1  one-cycle write strobe to the sound block
snd_data  out  16  word to the sound block, valid while snd_wr_en is high
fifo_empty  out  1  FIFO holds no entries
fifo_full  out  1  FIFO holds DEPTH entries
fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky; set when a push is dropped
busy  out  1  high when state != RUN, or the FIFO is not empty

Behaviour:
- Reset (async, rst=1): FIFO empty, count 0, state RUN, snd_wr_en 0, snd_data 0, overflow 0, prescaler and wait counter 0. Reset emits no silence writes.
- FIFO entry: 17 bits, {addr, data_in}.
- Push rules:
  - A push is accepted when en && wr_en && !fifo_full.
  - fifo_full is evaluated before any pop in the same cycle. A push while full is dropped and sets overflow, even if a pop occurs that cycle.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop when not full leaves the count unchanged.
- snd_wr_en, snd_data: registered. snd_wr_en defaults to 0 each cycle; snd_data holds its last value.
- Flush priority: flush and rst outrank everything.
- State RUN:
  - On each edge with the FIFO non-empty, pop the head.
  - Note entry: on the same edge, snd_data <= data and snd_wr_en <= 1. State stays RUN, so back-to-back notes give consecutive pulses.
  - Wait entry with W=0: no-op. The next entry may pop on the following edge.
  - Wait entry with W≥1: load the wait counter with W, clear the prescaler, go to WAIT.
- State WAIT:
  - The prescaler counts 0..TICK_DIV-1. On wrap, the wait counter decrements.
  - Transition to RUN occurs such that the next pop happens on edge M + W*TICK_DIV, where M is the edge that popped the wait entry.
  - No pops occur in WAIT.
  - Pushes are still accepted.
  - Counters are 16-bit + $clog2(TICK_DIV) wide; no overflow is possible.
- Flush (any state):
  - Clears the FIFO and overflow.
  - Aborts any wait.
  - Enters SILENCE with channel index 0.
  - A push in the same cycle is discarded.
- State SILENCE:
  - Emits 0x0000, 0x4000, 0x8000, 0xC000 on four consecutive edges, each with snd_wr_en=1, then returns to RUN.
  - Pushes during SILENCE are accepted and play after it.
  - A flush during SILENCE restarts at channel 0 and clears the FIFO again.
- busy is combinational from state and fifo_empty.

Test Plan:
1. Idle, push note 0x4123 on edge N → snd_wr_en high for exactly the cycle after edge N+1, snd_data=0x4123; fifo_empty returns to 1.
2. Push note 0x0100, note 0x4200, note 0x8300 back-to-back → three consecutive snd_wr_en cycles carrying those values in order.
3. TICK_DIV=4: push note 0x0010, wait 3, note 0x4020 → the two snd_wr_en pulses are 13 cycles apart; busy is high throughout; a wait of 0 inserts exactly 1 extra cycle.
4. With playback stalled in a long wait, push DEPTH+1 notes → fifo_full=1, fifo_count=DEPTH, overflow=1; the last word is never emitted.
5. Flush mid-wait with 5 entries queued → writes 0x0000, 0x4000, 0x8000, 0xC000 on 4 consecutive cycles; FIFO empty; overflow 0; queued notes never played; busy falls after the 4th write.
6. Assert rst asynchronously mid-wait and between clock edges → snd_wr_en, fifo_count, and busy go to 0 immediately; no silence writes follow deassertion.

Source files
------------

// File: rtl/sound_sequencer.sv
// Timed command player: a FIFO of note/wait words feeds one-cycle writes to the
// 4-channel square-wave sound block, paced by a tick prescaler.
module sound_sequencer #(
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     wr_en,
  input  logic                     addr,
  input  logic [15:0]              data_in,
  input  logic                     flush,
  output logic                     snd_wr_en,
  output logic [15:0]              snd_data,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_SILENCE} state_t;

  state_t        state, next_state;
  logic [16:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [15:0]   wait_cnt;
  logic [PW-1:0] presc;
  logic [1:0]    sil_idx;

  logic [16:0]   head;
  logic          push_req, do_push, do_pop, wait_done, load_wait;

  assign head       = mem[rd_ptr];
  assign push_req   = en && wr_en;
  assign fifo_count = count;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (AW+1)'(DEPTH));
  assign busy       = (state != ST_RUN) || !fifo_empty;

  // The final prescaler wrap of a wait doubles as a pop slot, so the entry after
  // a wait of W pops exactly W*TICK_DIV edges after the wait itself popped.
  assign wait_done  = (state == ST_WAIT) && (presc == PRESC_LAST) && (wait_cnt == 16'd1);
  assign do_push    = push_req && !fifo_full && !flush;
  assign do_pop     = !flush && !fifo_empty && ((state == ST_RUN) || wait_done);
  assign load_wait  = do_pop && head[16] && (head[15:0] != 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = ST_SILENCE;
    end else begin
      case (state)
        ST_RUN:     if (load_wait) next_state = ST_WAIT;
        ST_WAIT:    if (wait_done) next_state = load_wait ? ST_WAIT : ST_RUN;
        ST_SILENCE: if (sil_idx == 2'd3) next_state = ST_RUN;
        default:    next_state = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {addr, data_in};
  end

  // snd_wr_en is a single-cycle strobe; snd_data is only meaningful while it is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      wait_cnt  <= '0;
      presc     <= '0;
      sil_idx   <= '0;
      snd_wr_en <= 1'b0;
      snd_data  <= '0;
    end else begin
      snd_wr_en <= 1'b0;
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
        wait_cnt <= '0;
        presc    <= '0;
        sil_idx  <= '0;
      end else begin
        if (push_req && fifo_full) overflow <= 1'b1;
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({do_push, do_pop})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase

        if (do_pop && !head[16]) begin
          snd_data  <= head[15:0];
          snd_wr_en <= 1'b1;
        end

        if (load_wait) begin
          wait_cnt <= head[15:0];
          presc    <= '0;
        end else if (state == ST_WAIT) begin
          if (presc == PRESC_LAST) begin
            presc    <= '0;
            wait_cnt <= wait_cnt - 16'd1;
          end else begin
            presc <= presc + PW'(1);
          end
        end

        if (state == ST_SILENCE) begin
          snd_data  <= {sil_idx, 14'd0};
          snd_wr_en <= 1'b1;
          sil_idx   <= sil_idx + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer with DEPTH=8, TICK_DIV=4; expected values
// are hand-computed edge counts and word values.
module tb_sound_sequencer;
  localparam int DEPTH    = 8;
  localparam int TICK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, wr_en, addr, flush;
  logic [15:0] data_in;
  logic        snd_wr_en;
  logic [15:0] snd_data;
  logic        fifo_empty, fifo_full, overflow, busy;
  logic [3:0]  fifo_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [15:0] exp_q[$];

  sound_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .addr(addr), .data_in(data_in),
    .flush(flush), .snd_wr_en(snd_wr_en), .snd_data(snd_data),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_count(fifo_count),
    .overflow(overflow), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic a, input logic [15:0] d);
    en = 1'b1; wr_en = 1'b1; addr = a; data_in = d;
    tick();
    en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic quiet_window(input string tag, input int n);
    int pulses;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (snd_wr_en) pulses++;
    end
    check(tag, pulses, 0);
  endtask

  initial begin
    int t0, t1;
    logic busy_ok;
    rst = 1'b1; en = 1'b0; wr_en = 1'b0; addr = 1'b0; data_in = '0; flush = 1'b0;
    #12 rst = 1'b0;

    // reset state
    check("rst_wr_en", snd_wr_en, 0);
    check("rst_data", snd_data, 16'h0000);
    check("rst_empty", fifo_empty, 1);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);

    // 1: single note
    push(1'b0, 16'h4123);
    check("t1_no_early", snd_wr_en, 0);
    check("t1_count", fifo_count, 1);
    check("t1_busy", busy, 1);
    tick();
    check("t1_pulse", snd_wr_en, 1);
    check("t1_data", snd_data, 16'h4123);
    check("t1_empty", fifo_empty, 1);
    tick();
    check("t1_one_cycle", snd_wr_en, 0);
    check("t1_hold", snd_data, 16'h4123);

    // 2: back-to-back notes
    exp_q = '{16'h0100, 16'h4200, 16'h8300};
    push(1'b0, 16'h0100);
    push(1'b0, 16'h4200);
    check("t2_p0", snd_wr_en, 1);
    check("t2_d0", snd_data, exp_q.pop_front());
    push(1'b0, 16'h8300);
    check("t2_p1", snd_wr_en, 1);
    check("t2_d1", snd_data, exp_q.pop_front());
    tick();
    check("t2_p2", snd_wr_en, 1);
    check("t2_d2", snd_data, exp_q.pop_front());
    tick();
    check("t2_end", snd_wr_en, 0);

    // 3: wait of 3 ticks -> pulses 13 edges apart
    push(1'b0, 16'h0010);
    push(1'b1, 16'd3);
    check("t3_p0", snd_wr_en, 1);
    check("t3_d0", snd_data, 16'h0010);
    t0 = cyc;
    push(1'b0, 16'h4020);
    busy_ok = 1'b1;
    t1 = -1;
    for (int i = 0; i < 30 && t1 < 0; i++) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      if (snd_wr_en) t1 = cyc;
    end
    check("t3_gap", t1 - t0, 13);
    check("t3_d1", snd_data, 16'h4020);
    check("t3_busy", busy_ok, 1);
    tick();
    check("t3_idle", busy, 0);

    // 3b: wait of 0 adds exactly one cycle
    push(1'b0, 16'h0011);
    push(1'b1, 16'd0);
    check("t3b_p0", snd_wr_en, 1);
    t0 = cyc;
    push(1'b0, 16'h4021);
    check("t3b_gap_quiet", snd_wr_en, 0);
    tick();
    check("t3b_p1", snd_wr_en, 1);
    check("t3b_d1", snd_data, 16'h4021);
    check("t3b_gap", cyc - t0, 2);

    // 4: overflow while stalled in a long wait
    push(1'b1, 16'd100);
    for (int i = 1; i <= DEPTH + 1; i++) push(1'b0, 16'(i));
    check("t4_full", fifo_full, 1);
    check("t4_count", fifo_count, DEPTH);
    check("t4_ovf", overflow, 1);
    check("t4_busy", busy, 1);
    check("t4_quiet", snd_wr_en, 0);
    exp_q.delete();
    for (int i = 1; i <= DEPTH; i++) exp_q.push_back(16'(i));
    for (int i = 0; i < 600 && exp_q.size() > 0; i++) begin
      tick();
      if (snd_wr_en) check("t4_play", snd_data, exp_q.pop_front());
    end
    check("t4_all_played", exp_q.size(), 0);
    quiet_window("t4_dropped_never", 10);
    check("t4_ovf_sticky", overflow, 1);
    check("t4_empty", fifo_empty, 1);

    // 5: flush mid-wait with 5 entries queued
    push(1'b1, 16'd50);
    for (int i = 0; i < 5; i++) push(1'b0, 16'h0aa0 + 16'(i));
    check("t5_count", fifo_count, 5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5_empty", fifo_empty, 1);
    check("t5_ovf", overflow, 0);
    check("t5_busy", busy, 1);
    check("t5_no_write", snd_wr_en, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t5_sil_we", snd_wr_en, 1);
      check("t5_sil_d", snd_data, 32'(k) << 14);
      check("t5_sil_busy", busy, (k < 3) ? 1 : 0);
    end
    quiet_window("t5_notes_gone", 10);

    // 5b: flush discards a simultaneous push; flush during silence restarts
    flush = 1'b1; en = 1'b1; wr_en = 1'b1; addr = 1'b0; data_in = 16'h0555;
    tick();
    flush = 1'b0; en = 1'b0; wr_en = 1'b0;
    check("t5b_discard", fifo_count, 0);
    tick();
    check("t5b_s0", snd_data, 16'h0000);
    tick();
    check("t5b_s1", snd_data, 16'h4000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5b_restart_quiet", snd_wr_en, 0);
    push(1'b0, 16'h8777);
    check("t5b_r0", snd_data, 16'h0000);
    tick();
    check("t5b_r1", snd_data, 16'h4000);
    tick();
    check("t5b_r2", snd_data, 16'h8000);
    tick();
    check("t5b_r3", snd_data, 16'hC000);
    tick();
    check("t5b_note_we", snd_wr_en, 1);
    check("t5b_note", snd_data, 16'h8777);

    // 6: asynchronous reset mid-wait, between edges
    push(1'b1, 16'd100);
    push(1'b0, 16'h0333);
    push(1'b0, 16'h0444);
    check("t6_count_pre", fifo_count, 2);
    #3 rst = 1'b1;
    #1;
    check("t6_count", fifo_count, 0);
    check("t6_busy", busy, 0);
    check("t6_we", snd_wr_en, 0);
    #2 rst = 1'b0;
    quiet_window("t6_no_silence", 20);
    check("t6_data", snd_data, 16'h0000);

    // 6b: asynchronous reset while a write strobe is high
    push(1'b0, 16'h0555);
    push(1'b0, 16'h0666);
    check("t6b_we_pre", snd_wr_en, 1);
    #2 rst = 1'b1;
    #1;
    check("t6b_we", snd_wr_en, 0);
    check("t6b_count", fifo_count, 0);
    #2 rst = 1'b0;
    quiet_window("t6b_quiet", 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
